// File: rtl/router_pkg.sv
// Shared router definitions: packet geometry, requester indices, buffer FSM encoding.
package router_pkg;
  localparam int DATA_WIDTH = 64;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;

  // Requester index, also the encoding of the per-VC priority bit
  localparam logic REQ_CCW = 1'b0;
  localparam logic REQ_PE  = 1'b1;

  typedef enum logic [1:0] {
    BUF_EMPTY   = 2'b00,
    BUF_GRANTED = 2'b01,
    BUF_FULL    = 2'b10
  } buf_state_t;
endpackage

// File: rtl/out_vc_buffer.sv
// One virtual channel of the CCW output stage: 2-way round-robin between the
// CCW-forwarding and PE-injection requesters, a single-packet buffer with hop
// shift on capture, and the EMPTY/GRANTED/FULL FSM that sequences them.
module out_vc_buffer #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int HOP_MSB    = router_pkg::HOP_MSB,
  parameter int HOP_LSB    = router_pkg::HOP_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_ccw,
  input  logic                  i_req_pe,
  input  logic [DATA_WIDTH-1:0] i_data_ccw,
  input  logic [DATA_WIDTH-1:0] i_data_pe,
  input  logic                  i_launch,
  output logic                  o_grant_ccw,
  output logic                  o_grant_pe,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);
  import router_pkg::*;

  buf_state_t            r_state, w_state_nxt;
  logic                  r_prio;       // requester currently holding priority
  logic                  r_sel;        // requester granted, selects capture source
  logic                  r_grant_ccw, r_grant_pe;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  w_grant;
  logic                  w_win_pe;
  logic [DATA_WIDTH-1:0] w_src, w_cap;

  // Next-state logic; grants are only decided in EMPTY
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    // PE wins when it is alone or when both request and PE holds priority
    w_win_pe    = i_req_pe & (~i_req_ccw | (r_prio == REQ_PE));
    case (r_state)
      BUF_EMPTY: begin
        if (i_req_ccw | i_req_pe) begin
          w_grant     = 1'b1;
          w_state_nxt = BUF_GRANTED;
        end
      end
      BUF_GRANTED: w_state_nxt = BUF_FULL;
      BUF_FULL:    if (i_launch) w_state_nxt = BUF_EMPTY;
      default:     w_state_nxt = BUF_EMPTY;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BUF_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Registered grant pulses; priority passes to the loser after every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_ccw <= 1'b0;
      r_grant_pe  <= 1'b0;
      r_prio      <= REQ_CCW;
      r_sel       <= REQ_CCW;
    end else begin
      r_grant_ccw <= w_grant & ~w_win_pe;
      r_grant_pe  <= w_grant &  w_win_pe;
      if (w_grant) begin
        r_sel  <= w_win_pe ? REQ_PE  : REQ_CCW;
        r_prio <= w_win_pe ? REQ_CCW : REQ_PE;
      end
    end
  end

  // Capture source mux with the hop field halved; other bits pass through
  always_comb begin
    w_src = (r_sel == REQ_PE) ? i_data_pe : i_data_ccw;
    w_cap = w_src;
    w_cap[HOP_MSB:HOP_LSB] = w_src[HOP_MSB:HOP_LSB] >> 1;
  end

  // Buffer capture at the edge closing the grant cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_buf <= '0;
    else if (r_state == BUF_GRANTED) r_buf <= w_cap;
  end

  assign o_grant_ccw = r_grant_ccw;
  assign o_grant_pe  = r_grant_pe;
  assign o_full      = (r_state == BUF_FULL);
  assign o_data      = r_buf;
endmodule

// File: rtl/ccw_output.sv
// CCW output stage: two VC buffers feeding one link. The polarity of the
// current cycle decides which VC may launch so that the packet lands on the
// following cycle, whose polarity matches that VC at the receiver.
module ccw_output #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int HOP_MSB    = router_pkg::HOP_MSB,
  parameter int HOP_LSB    = router_pkg::HOP_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_ccw_even,
  input  logic                  request_ccw_odd,
  input  logic                  request_pe_even,
  input  logic                  request_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_even,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_pe_even,
  input  logic [DATA_WIDTH-1:0] data_in_pe_odd,
  output logic                  grant_ccw_even,
  output logic                  grant_ccw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  input  logic                  ccwro,
  output logic                  ccwso,
  output logic [DATA_WIDTH-1:0] ccwdo
);
  import router_pkg::*;

  logic                  w_full_even, w_full_odd;
  logic [DATA_WIDTH-1:0] w_buf_even, w_buf_odd;
  logic                  w_launch_even, w_launch_odd;
  logic                  r_ccwso;
  logic [DATA_WIDTH-1:0] r_ccwdo;

  // Odd goes out when the next cycle is odd (polarity 0 now), even otherwise
  assign w_launch_odd  = ~polarity & ccwro & w_full_odd;
  assign w_launch_even =  polarity & ccwro & w_full_even;

  out_vc_buffer #(.DATA_WIDTH(DATA_WIDTH), .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)) u_even (
    .clk        (clk),
    .rst        (rst),
    .i_req_ccw  (request_ccw_even),
    .i_req_pe   (request_pe_even),
    .i_data_ccw (data_in_ccw_even),
    .i_data_pe  (data_in_pe_even),
    .i_launch   (w_launch_even),
    .o_grant_ccw(grant_ccw_even),
    .o_grant_pe (grant_pe_even),
    .o_full     (w_full_even),
    .o_data     (w_buf_even)
  );

  out_vc_buffer #(.DATA_WIDTH(DATA_WIDTH), .HOP_MSB(HOP_MSB), .HOP_LSB(HOP_LSB)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .i_req_ccw  (request_ccw_odd),
    .i_req_pe   (request_pe_odd),
    .i_data_ccw (data_in_ccw_odd),
    .i_data_pe  (data_in_pe_odd),
    .i_launch   (w_launch_odd),
    .o_grant_ccw(grant_ccw_odd),
    .o_grant_pe (grant_pe_odd),
    .o_full     (w_full_odd),
    .o_data     (w_buf_odd)
  );

  // Link registers; data holds its last value when nothing launches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ccwso <= 1'b0;
      r_ccwdo <= '0;
    end else begin
      r_ccwso <= w_launch_odd | w_launch_even;
      if (w_launch_odd)       r_ccwdo <= w_buf_odd;
      else if (w_launch_even) r_ccwdo <= w_buf_even;
    end
  end

  assign ccwso = r_ccwso;
  assign ccwdo = r_ccwdo;
endmodule

// File: tb/tb_ccw_output.sv
// Directed bench for ccw_output: a per-cycle vector table for the single
// packet and even-VC contention cases, plus hand sequences for backpressure,
// back-to-back packets and asynchronous reset.
module tb_ccw_output;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        polarity, ccwro;
  logic        request_ccw_even, request_ccw_odd, request_pe_even, request_pe_odd;
  logic [63:0] data_in_ccw_even, data_in_ccw_odd, data_in_pe_even, data_in_pe_odd;
  logic        grant_ccw_even, grant_ccw_odd, grant_pe_even, grant_pe_odd;
  logic        ccwso;
  logic [63:0] ccwdo;

  int n_chk = 0;
  int n_err = 0;

  // Payloads and their hop-shifted images
  localparam logic [63:0] D_CO  = 64'h0003_0000_0000_00AA, X_CO  = 64'h0001_0000_0000_00AA;
  localparam logic [63:0] D_CE  = 64'h0004_0000_0000_0011, X_CE  = 64'h0002_0000_0000_0011;
  localparam logic [63:0] D_PE  = 64'h00FF_0000_0000_0022, X_PE  = 64'h007F_0000_0000_0022;
  localparam logic [63:0] D_PO1 = 64'hAB08_0000_0000_0033, X_PO1 = 64'hAB04_0000_0000_0033;
  localparam logic [63:0] D_PO2 = 64'h0010_0000_0000_0044, X_PO2 = 64'h0008_0000_0000_0044;

  ccw_output dut (
    .clk(clk), .rst(rst), .polarity(polarity),
    .request_ccw_even(request_ccw_even), .request_ccw_odd(request_ccw_odd),
    .request_pe_even(request_pe_even), .request_pe_odd(request_pe_odd),
    .data_in_ccw_even(data_in_ccw_even), .data_in_ccw_odd(data_in_ccw_odd),
    .data_in_pe_even(data_in_pe_even), .data_in_pe_odd(data_in_pe_odd),
    .grant_ccw_even(grant_ccw_even), .grant_ccw_odd(grant_ccw_odd),
    .grant_pe_even(grant_pe_even), .grant_pe_odd(grant_pe_odd),
    .ccwro(ccwro), .ccwso(ccwso), .ccwdo(ccwdo)
  );

  always #5 clk = ~clk;

  // Bit order for requests and grants: {pe_odd, pe_even, ccw_odd, ccw_even}
  typedef struct {
    logic        pol;
    logic [3:0]  rq;
    logic        ro;
    logic [3:0]  gnt;
    logic        so;
    logic [63:0] dout;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [3:0] gnts();
    return {grant_pe_odd, grant_pe_even, grant_ccw_odd, grant_ccw_even};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input logic [3:0] g, input logic so, input logic [63:0] d);
    chk({nm, " grants"}, {60'd0, gnts()}, {60'd0, g});
    chk({nm, " ccwso"}, {63'd0, ccwso}, {63'd0, so});
    chk({nm, " ccwdo"}, ccwdo, d);
  endtask

  // Apply inputs for one cycle, then sample just after the closing edge
  task automatic step(input logic p, input logic [3:0] rq, input logic ro);
    polarity         = p;
    request_ccw_even = rq[0];
    request_ccw_odd  = rq[1];
    request_pe_even  = rq[2];
    request_pe_odd   = rq[3];
    ccwro            = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 4'b0000, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    // Single odd packet, then sustained even contention
    tbl[0]  = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b0, 64'h0};
    tbl[1]  = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 64'h0};
    tbl[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, X_CO};
    tbl[3]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, X_CO};
    tbl[4]  = '{1'b1, 4'b0101, 1'b1, 4'b0001, 1'b0, X_CO};
    tbl[5]  = '{1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, X_CO};
    tbl[6]  = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, X_CE};
    tbl[7]  = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b0, X_CE};
    tbl[8]  = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, X_CE};
    tbl[9]  = '{1'b0, 4'b0101, 1'b1, 4'b0000, 1'b0, X_CE};
    tbl[10] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b1, X_PE};
    tbl[11] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b0, X_PE};
    tbl[12] = '{1'b1, 4'b0101, 1'b1, 4'b0000, 1'b0, X_PE};

    data_in_ccw_even = D_CE;
    data_in_ccw_odd  = D_CO;
    data_in_pe_even  = D_PE;
    data_in_pe_odd   = D_PO1;
    polarity = 1'b0; ccwro = 1'b1;
    request_ccw_even = 1'b0; request_ccw_odd = 1'b0;
    request_pe_even  = 1'b0; request_pe_odd  = 1'b0;

    // Reset asserted between clock edges takes effect at once
    #2 rst = 1'b1;
    #1 check_out("reset", 4'b0000, 1'b0, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].pol, tbl[i].rq, tbl[i].ro);
      check_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].so, tbl[i].dout);
    end

    // Backpressure: fill both buffers, hold with ccwro low, then release
    do_reset();
    step(1'b0, 4'b0110, 1'b0);
    check_out("bp grant", 4'b0110, 1'b0, 64'h0);
    step(1'b1, 4'b0110, 1'b0);
    check_out("bp capture", 4'b0000, 1'b0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step(i[0], 4'b1111, 1'b0);
      check_out($sformatf("bp hold%0d", i), 4'b0000, 1'b0, 64'h0);
    end
    step(1'b1, 4'b0000, 1'b0);
    check_out("bp drop", 4'b0000, 1'b0, 64'h0);
    step(1'b0, 4'b0000, 1'b1);
    check_out("bp odd out", 4'b0000, 1'b1, X_CO);
    step(1'b1, 4'b0000, 1'b1);
    check_out("bp even out", 4'b0000, 1'b1, X_PE);
    step(1'b0, 4'b0000, 1'b1);
    check_out("bp idle", 4'b0000, 1'b0, X_PE);

    // Back-to-back PE odd packets
    do_reset();
    data_in_pe_odd = D_PO1;
    step(1'b0, 4'b1000, 1'b1);
    check_out("b2b grant1", 4'b1000, 1'b0, 64'h0);
    step(1'b1, 4'b1000, 1'b1);
    check_out("b2b capture1", 4'b0000, 1'b0, 64'h0);
    data_in_pe_odd = D_PO2;
    step(1'b0, 4'b1000, 1'b1);
    check_out("b2b launch1", 4'b0000, 1'b1, X_PO1);
    step(1'b1, 4'b1000, 1'b1);
    check_out("b2b grant2", 4'b1000, 1'b0, X_PO1);
    step(1'b0, 4'b1000, 1'b1);
    check_out("b2b capture2", 4'b0000, 1'b0, X_PO1);
    step(1'b1, 4'b0000, 1'b1);
    check_out("b2b wait", 4'b0000, 1'b0, X_PO1);
    // Odd launches while the even VC gets a grant in the same edge
    step(1'b0, 4'b0001, 1'b1);
    check_out("b2b launch2", 4'b0001, 1'b1, X_PO2);

    // Mid-cycle reset with a grant and a send in flight
    #2 rst = 1'b1;
    #1 check_out("mid reset", 4'b0000, 1'b0, 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 4'b0000, 1'b1);
    check_out("post reset", 4'b0000, 1'b0, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
